// File: rtl/narrow_to_wide_burst_bridge.sv
// Narrow byte-stream command parser that packs data words into wide
// write beats with address, last flag, backpressure and idle timeout.
module narrow_to_wide_burst_bridge #(
   parameter int LOW_DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int BRUST_SIZE_LOG = 2,
   parameter int LEN_WIDTH = 8,
   parameter int unsigned CMD_DATA_TRAN = 8'h01,
   parameter int TIMEOUT_CYCLES = 255,
   localparam int HIGH_DATA_WIDTH = LOW_DATA_WIDTH * (2 ** BRUST_SIZE_LOG)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       low_read_valid,
   input  logic [LOW_DATA_WIDTH-1:0]  low_read_data,
   output logic                       low_read_ready,
   output logic [ADDR_WIDTH-1:0]      high_write_addr,
   output logic [HIGH_DATA_WIDTH-1:0] high_write_data,
   output logic                       high_write_last,
   output logic                       high_write_valid,
   input  logic                       high_write_ready,
   output logic                       busy,
   output logic                       err_timeout
);
   localparam int LANES = 2 ** BRUST_SIZE_LOG;
   localparam int ADDR_WORDS = (ADDR_WIDTH + LOW_DATA_WIDTH - 1) / LOW_DATA_WIDTH;
   localparam int AB = ADDR_WORDS * LOW_DATA_WIDTH;
   localparam int WCW = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
   localparam int LNW = (BRUST_SIZE_LOG > 0) ? BRUST_SIZE_LOG : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, ADDR, LEN, DATA} state_t;

   state_t state, state_nx;
   logic [WCW-1:0] word_cnt;
   logic [AB-1:0] addr_buf;
   logic [LEN_WIDTH-1:0] beats_m1;
   logic [LEN_WIDTH-1:0] beat_idx;
   logic [LNW-1:0] lane;
   logic [HIGH_DATA_WIDTH-1:0] data_buf;
   logic [HIGH_DATA_WIDTH-1:0] beat;
   logic [TW-1:0] tmo_cnt;
   logic accept, lane_last, word_last, beat_last;
   logic is_cmd, tmo_hit, load;

   assign accept = low_read_valid && low_read_ready;
   assign lane_last = lane == LNW'(LANES - 1);
   assign word_last = word_cnt == WCW'(ADDR_WORDS - 1);
   assign beat_last = beat_idx == beats_m1;
   assign is_cmd = low_read_data == LOW_DATA_WIDTH'(CMD_DATA_TRAN);
   assign load = (state == DATA) && accept && lane_last;
   // Stalled cycles are not idle: the sink is holding us, not the source.
   assign tmo_hit = (state != IDLE) && !accept && low_read_ready &&
                    (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      beat = data_buf;
      beat[lane*LOW_DATA_WIDTH +: LOW_DATA_WIDTH] = low_read_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (tmo_hit) begin
         state_nx = IDLE;
      end else if (accept) begin
         unique case (state)
            IDLE: if (is_cmd) state_nx = ADDR;
            ADDR: if (word_last) state_nx = LEN;
            LEN:  state_nx = DATA;
            DATA: if (lane_last && beat_last) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      low_read_ready = !((state == DATA) && lane_last &&
                         high_write_valid && !high_write_ready);
      busy = state != IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= '0;
         addr_buf <= '0;
         beats_m1 <= '0;
         beat_idx <= '0;
         lane <= '0;
         data_buf <= '0;
         tmo_cnt <= '0;
         err_timeout <= 1'b0;
         high_write_valid <= 1'b0;
         high_write_last <= 1'b0;
         high_write_addr <= '0;
         high_write_data <= '0;
      end else begin
         err_timeout <= tmo_hit;
         if ((state == IDLE) || accept || tmo_hit) tmo_cnt <= '0;
         else if (low_read_ready) tmo_cnt <= tmo_cnt + TW'(1);
         if (accept) begin
            unique case (state)
               IDLE: word_cnt <= '0;
               ADDR: begin
                  addr_buf[word_cnt*LOW_DATA_WIDTH +: LOW_DATA_WIDTH] <= low_read_data;
                  word_cnt <= word_cnt + WCW'(1);
               end
               LEN: begin
                  beats_m1 <= low_read_data[LEN_WIDTH-1:0];
                  beat_idx <= '0;
                  lane <= '0;
               end
               DATA: begin
                  data_buf <= beat;
                  lane <= lane_last ? '0 : lane + LNW'(1);
                  if (lane_last) beat_idx <= beat_idx + LEN_WIDTH'(1);
               end
               default: ;
            endcase
         end
         if (load) begin
            high_write_valid <= 1'b1;
            high_write_data <= beat;
            high_write_addr <= addr_buf[ADDR_WIDTH-1:0] + ADDR_WIDTH'(beat_idx);
            high_write_last <= beat_last;
         end else if (high_write_valid && high_write_ready) begin
            high_write_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_narrow_to_wide_burst_bridge.sv
// Randomised scoreboard bench for narrow_to_wide_burst_bridge.
module tb_narrow_to_wide_burst_bridge;
   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic low_read_valid = 1'b0;
   logic [7:0] low_read_data = '0;
   logic low_read_ready;
   logic [15:0] high_write_addr;
   logic [31:0] high_write_data;
   logic high_write_last;
   logic high_write_valid;
   logic high_write_ready = 1'b1;
   logic busy;
   logic err_timeout;

   typedef struct packed {
      logic [15:0] addr;
      logic [31:0] data;
      logic last;
   } beat_t;

   beat_t exp_q[$];
   int errors = 0;
   int checks = 0;
   int tmo_pulses = 0;
   int stall_seen = 0;
   int acc_cnt = 0;
   int acc_at_stall = -1;
   int sink_mode = 0;
   logic [7:0] dq[$];

   narrow_to_wide_burst_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .low_read_valid(low_read_valid), .low_read_data(low_read_data),
      .low_read_ready(low_read_ready),
      .high_write_addr(high_write_addr), .high_write_data(high_write_data),
      .high_write_last(high_write_last), .high_write_valid(high_write_valid),
      .high_write_ready(high_write_ready),
      .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (sink_mode)
            0: high_write_ready = 1'b1;
            1: high_write_ready = 1'($urandom_range(0, 1));
            default: high_write_ready = 1'b0;
         endcase
      end
   end

   initial begin
      logic held;
      beat_t h, e;
      held = 1'b0;
      h = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held = 1'b0;
         end else begin
            if (err_timeout) tmo_pulses++;
            if (low_read_valid && low_read_ready) acc_cnt++;
            if (!low_read_ready) begin
               if (stall_seen == 0) acc_at_stall = acc_cnt;
               stall_seen++;
            end
            if (held) begin
               chk("hold_valid", 64'(high_write_valid), 64'(1));
               chk("hold_addr", 64'(high_write_addr), 64'(h.addr));
               chk("hold_data", 64'(high_write_data), 64'(h.data));
               chk("hold_last", 64'(high_write_last), 64'(h.last));
            end
            if (high_write_valid && high_write_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got addr %h data %h, expected none",
                           high_write_addr, high_write_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat_addr", 64'(high_write_addr), 64'(e.addr));
                  chk("beat_data", 64'(high_write_data), 64'(e.data));
                  chk("beat_last", 64'(high_write_last), 64'(e.last));
               end
            end
            held = high_write_valid && !high_write_ready;
            h = '{high_write_addr, high_write_data, high_write_last};
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic acc;
      int n;
      n = 0;
      low_read_valid = 1'b1;
      low_read_data = b;
      do begin
         @(negedge clk);
         acc = low_read_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 1000);
      low_read_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no accept, expected accept within 1000 cycles");
      end
   endtask

   task automatic send_packet(input logic [15:0] addr, input logic [7:0] len,
                              input logic [7:0] d[$], input int gap);
      beat_t b;
      for (int i = 0; i <= int'(len); i++) begin
         b.addr = addr + 16'(i);
         for (int j = 0; j < 4; j++) b.data[j*8 +: 8] = d[4*i + j];
         b.last = (i == int'(len));
         exp_q.push_back(b);
      end
      send_byte(8'h01);
      send_byte(addr[7:0]);
      send_byte(addr[15:8]);
      send_byte(len);
      for (int i = 0; i < d.size(); i++) begin
         if (gap > 0) tick($urandom_range(0, gap));
         send_byte(d[i]);
      end
   endtask

   task automatic rand_data(input int n);
      dq.delete();
      for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || high_write_valid) && n < 2000) begin
         tick(1);
         n++;
      end
      chk(name, 64'(exp_q.size()), 64'(0));
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before 500us");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a;
      logic [7:0] l, j;
      #2;
      chk("rst_valid", 64'(high_write_valid), 64'(0));
      chk("rst_last", 64'(high_write_last), 64'(0));
      chk("rst_addr", 64'(high_write_addr), 64'(0));
      chk("rst_data", 64'(high_write_data), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_err", 64'(err_timeout), 64'(0));
      tick(2);
      rst_n = 1'b1;
      tick(1);

      dq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      send_packet(16'h1234, 8'h00, dq, 0);
      drain("drain_single");

      dq.delete();
      for (int i = 0; i < 12; i++) dq.push_back(8'(i));
      send_packet(16'hFF00, 8'h02, dq, 0);
      drain("drain_three");

      rand_data(8);
      send_packet(16'hFFFF, 8'h01, dq, 0);
      drain("drain_wrap");

      send_byte(8'h55);
      send_byte(8'hFF);
      tick(1);
      chk("junk_busy", 64'(busy), 64'(0));

      sink_mode = 2;
      tick(1);
      stall_seen = 0;
      acc_cnt = 0;
      acc_at_stall = -1;
      rand_data(8);
      fork
         send_packet(16'h4000, 8'h01, dq, 0);
         begin
            int n;
            n = 0;
            while (stall_seen == 0 && n < 100) begin
               tick(1);
               n++;
            end
            tick(5);
            sink_mode = 0;
         end
      join
      drain("drain_bp");
      chk("bp_stall_seen", 64'(stall_seen > 0), 64'(1));
      chk("bp_stall_lane", 64'(acc_at_stall), 64'(11));

      sink_mode = 1;
      for (int p = 0; p < 20; p++) begin
         if ($urandom_range(0, 2) == 0) begin
            j = 8'($urandom);
            if (j == 8'h01) j = 8'h02;
            send_byte(j);
         end
         a = 16'($urandom);
         l = 8'($urandom_range(0, 4));
         rand_data(4 * (int'(l) + 1));
         send_packet(a, l, dq, 2);
      end
      drain("drain_random");
      sink_mode = 0;
      tick(2);
      chk("no_spurious_tmo", 64'(tmo_pulses), 64'(0));

      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h10);
      send_byte(8'h00);
      send_byte(8'hAA);
      tick(TMO - 1);
      chk("tmo_busy_before", 64'(busy), 64'(1));
      chk("tmo_pulse_before", 64'(tmo_pulses), 64'(0));
      tick(2);
      chk("tmo_pulse", 64'(tmo_pulses), 64'(1));
      chk("tmo_busy_after", 64'(busy), 64'(0));
      chk("tmo_no_beat", 64'(high_write_valid), 64'(0));
      rand_data(4);
      send_packet(16'h1000, 8'h00, dq, 0);
      drain("drain_after_tmo");
      chk("tmo_single", 64'(tmo_pulses), 64'(1));

      sink_mode = 2;
      tick(1);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h20);
      send_byte(8'h01);
      for (int i = 0; i < 6; i++) send_byte(8'(8'h30 + i));
      chk("pre_rst_valid", 64'(high_write_valid), 64'(1));
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(high_write_valid), 64'(0));
      chk("arst_last", 64'(high_write_last), 64'(0));
      chk("arst_addr", 64'(high_write_addr), 64'(0));
      chk("arst_data", 64'(high_write_data), 64'(0));
      chk("arst_busy", 64'(busy), 64'(0));
      chk("arst_err", 64'(err_timeout), 64'(0));
      sink_mode = 0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
      exp_q.delete();
      rand_data(8);
      send_packet(16'h0ABC, 8'h01, dq, 1);
      drain("drain_after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
